alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Command-issue stage directly upstream of the ALU. Accepts operation commands over a valid/ready interface into a small FIFO and drives the ALU mode/enable, opcode and operand inputs for exactly one clock per command. It samples the ALU result and interrupt one cycle later and returns them over a valid/ready response interface. When a command raised the ALU interrupt, it pulses the ALU interrupt clear so no interrupt state leaks into the next command.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- alu_clk  in  1  clock; all logic on rising edge
- alu_rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; = !full, registered-state only (no combinational path from outputs)
- cmd_mode  in  1  0 = port-A operation, 1 = port-B operation
- cmd_op  in  opcode_t  opcode for the selected port
- cmd_a, cmd_b  in  data_t  operands
- alu_enable, alu_enable_a, alu_enable_b  out  1  ALU mode controls, registered
- alu_op_a, alu_op_b  out  opcode_t  ALU opcodes, registered
- alu_in_a, alu_in_b  out  data_t  ALU operands, registered
- alu_irq_clr  out  1  ALU interrupt clear, registered
- alu_out  in  data_t  ALU result
- alu_irq  in  1  ALU interrupt
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  data_t  captured alu_out
- rsp_irq  out  1  captured alu_irq
- irq_count  out  8  saturating count of responses with rsp_irq = 1
- busy  out  1  state != IDLE or FIFO non-empty

## Operation
- FIFO: push on cmd_valid & cmd_ready. Stores {mode, op, a, b}. Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits. Pop only on entry to ISSUE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - All ALU control outputs are 0.
  - If the FIFO is non-empty, pop the head and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - alu_enable = 1.
  - mode 0: alu_enable_a = 1, alu_enable_b = 0, alu_op_a = op.
  - mode 1: alu_enable_a = 0, alu_enable_b = 1, alu_op_b = op.
  - alu_in_a/b = a/b.
  - The unused opcode keeps its previous value.
  - Always go to WAIT.
- WAIT (exactly 1 cycle):
  - Enables drop to 0; opcodes and operands hold.
  - At the closing edge: rsp_data <= alu_out, rsp_irq <= alu_irq. If alu_irq = 1, irq_count increments, saturating at 8'hFF.
  - Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_irq are stable until the handshake.
  - alu_irq_clr = 1 for the first RESP cycle only, and only if rsp_irq = 1.
  - On rsp_ready: if the FIFO is non-empty, pop and go to ISSUE directly; else go to IDLE.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- The block does not interpret ALU results. Whatever alu_out holds during WAIT is returned, including values the ALU did not update.

## Timing
- Reset (async assert, sync-safe deassert):
  - FSM = IDLE, FIFO empty.
  - cmd_ready = 1.
  - All ALU-side outputs = 0; opcodes = first opcode_t enumerator.
  - rsp_valid = 0, rsp_data = 0, rsp_irq = 0, irq_count = 0, busy = 0.
- Reset mid-operation: the in-flight command, the held response and all FIFO contents are discarded. No alu_irq_clr pulse is issued.
- Latency: command accepted at edge E0 → ISSUE during cycle E1–E2 → ALU samples at E2 → capture at E3 → rsp_valid high after E3.
- Throughput: one command per 3 cycles when rsp_ready is held high.
- rsp_valid, once high, does not drop until rsp_ready is sampled high.
- When full, cmd_ready = 0. A pop in that cycle raises cmd_ready on the next cycle, not the same one.
- alu_enable_a and alu_enable_b are never both 1. alu_enable is 1 only in ISSUE.

## Test plan
- Single cmd: mode 0, op = first enumerator, a = 8'h3C, b = 8'h0F. Bench ALU model drives alu_out = 8'h0C, alu_irq = 0 in WAIT. Required: ISSUE shows alu_enable = 1, alu_enable_a = 1, alu_enable_b = 0; rsp_valid high 3 cycles after acceptance; rsp_data = 8'h0C; rsp_irq = 0; no alu_irq_clr pulse.
- IRQ: mode 1, a = 8'hFF, b = 8'h00; model drives alu_irq = 1. Required: rsp_irq = 1; alu_irq_clr high for exactly 1 cycle at the first RESP cycle; irq_count 0 → 1.
- Backpressure and full: DEPTH = 4, rsp_ready = 0, push 6 commands.
  - After 5 accepted (1 in flight + 4 queued), cmd_ready = 0.
  - Release rsp_ready: responses return in push order with no loss or duplication; cmd_ready reasserts the cycle after the first pop.
- Back-to-back: 4 queued, rsp_ready = 1. Required: RESP → ISSUE with no IDLE cycle; alu_enable pulses exactly every 3 cycles.
- Reset mid-operation: assert alu_rst_n = 0 during WAIT with 2 queued. Required: all outputs reach reset values without a clock edge; after release, busy = 0 and no response appears.
- Saturation: 256 interrupting commands. Required: irq_count holds at 8'hFF.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command-issue stage in front of the ALU: queues commands, drives the ALU for one
// cycle per command, captures the result one cycle later and returns it as a response.
package alu_cmd_pkg;

  typedef logic [7:0] data_t;

  typedef enum logic [2:0] {
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_ADD,
    OP_SUB,
    OP_SHL,
    OP_SHR,
    OP_PASSB
  } opcode_t;

  typedef struct packed {
    logic    mode;
    opcode_t op;
    data_t   a;
    data_t   b;
  } cmd_t;

endpackage

module alu_cmd_issuer
  import alu_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    alu_clk,
  input  logic    alu_rst_n,
  // command side
  input  logic    cmd_valid,
  output logic    cmd_ready,
  input  logic    cmd_mode,
  input  opcode_t cmd_op,
  input  data_t   cmd_a,
  input  data_t   cmd_b,
  // ALU side
  output logic    alu_enable,
  output logic    alu_enable_a,
  output logic    alu_enable_b,
  output opcode_t alu_op_a,
  output opcode_t alu_op_b,
  output data_t   alu_in_a,
  output data_t   alu_in_b,
  output logic    alu_irq_clr,
  input  data_t   alu_out,
  input  logic    alu_irq,
  // response side
  output logic    rsp_valid,
  input  logic    rsp_ready,
  output data_t   rsp_data,
  output logic    rsp_irq,
  output logic [7:0] irq_count,
  output logic    busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  state_t          state_q;
  cmd_t            cmd_in;
  cmd_t            head;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  assign cmd_in     = '{mode: cmd_mode, op: cmd_op, a: cmd_a, b: cmd_b};
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != CNT_FULL);
  assign push       = cmd_valid && cmd_ready;
  // A pop is exactly the transition into ISSUE, from IDLE or from an accepted response.
  assign pop        = !fifo_empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; contents are only ever read behind a valid count.
  always_ff @(posedge alu_clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM with registered ALU and response outputs
  // ---------------------------------------------------------------------------
  logic       alu_enable_q, alu_enable_a_q, alu_enable_b_q;
  opcode_t    alu_op_a_q, alu_op_b_q;
  data_t      alu_in_a_q, alu_in_b_q;
  logic       alu_irq_clr_q;
  logic       rsp_valid_q;
  data_t      rsp_data_q;
  logic       rsp_irq_q;
  logic [7:0] irq_count_q;

  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      state_q        <= ST_IDLE;
      alu_enable_q   <= 1'b0;
      alu_enable_a_q <= 1'b0;
      alu_enable_b_q <= 1'b0;
      alu_op_a_q     <= OP_AND;
      alu_op_b_q     <= OP_AND;
      alu_in_a_q     <= '0;
      alu_in_b_q     <= '0;
      alu_irq_clr_q  <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_irq_q      <= 1'b0;
      irq_count_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          alu_enable_q   <= 1'b0;
          alu_enable_a_q <= 1'b0;
          alu_enable_b_q <= 1'b0;
          alu_irq_clr_q  <= 1'b0;
          if (!fifo_empty) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          alu_enable_q   <= 1'b0;
          alu_enable_a_q <= 1'b0;
          alu_enable_b_q <= 1'b0;
          state_q        <= ST_WAIT;
        end
        ST_WAIT: begin
          rsp_data_q    <= alu_out;
          rsp_irq_q     <= alu_irq;
          rsp_valid_q   <= 1'b1;
          // The clear is a one-cycle pulse aligned with the first RESP cycle.
          alu_irq_clr_q <= alu_irq;
          if (alu_irq && (irq_count_q != 8'hFF)) irq_count_q <= irq_count_q + 8'd1;
          state_q       <= ST_RESP;
        end
        ST_RESP: begin
          alu_irq_clr_q <= 1'b0;
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= fifo_empty ? ST_IDLE : ST_ISSUE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Loading the popped command overrides the enable clears above.
      if (pop) begin
        alu_enable_q   <= 1'b1;
        alu_enable_a_q <= !head.mode;
        alu_enable_b_q <= head.mode;
        if (head.mode) alu_op_b_q <= head.op;
        else           alu_op_a_q <= head.op;
        alu_in_a_q     <= head.a;
        alu_in_b_q     <= head.b;
      end
    end
  end

  assign alu_enable   = alu_enable_q;
  assign alu_enable_a = alu_enable_a_q;
  assign alu_enable_b = alu_enable_b_q;
  assign alu_op_a     = alu_op_a_q;
  assign alu_op_b     = alu_op_b_q;
  assign alu_in_a     = alu_in_a_q;
  assign alu_in_b     = alu_in_b_q;
  assign alu_irq_clr  = alu_irq_clr_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_irq      = rsp_irq_q;
  assign irq_count    = irq_count_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized bench for alu_cmd_issuer: a behavioural ALU drives the DUT and a
// command-order scoreboard predicts every response and the interrupt count.
module tb_alu_cmd_issuer;
  import alu_cmd_pkg::*;

  logic       alu_clk;
  logic       alu_rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_mode;
  opcode_t    cmd_op;
  data_t      cmd_a, cmd_b;
  logic       alu_enable, alu_enable_a, alu_enable_b;
  opcode_t    alu_op_a, alu_op_b;
  data_t      alu_in_a, alu_in_b;
  logic       alu_irq_clr;
  data_t      alu_out;
  logic       alu_irq;
  logic       rsp_valid;
  logic       rsp_ready;
  data_t      rsp_data;
  logic       rsp_irq;
  logic [7:0] irq_count;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_rsp    = 0;
  int exp_irq_cnt = 0;
  cmd_t exp_q[$];

  alu_cmd_issuer #(.DEPTH(4)) dut (
    .alu_clk(alu_clk), .alu_rst_n(alu_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_irq_clr(alu_irq_clr), .alu_out(alu_out), .alu_irq(alu_irq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_irq(rsp_irq), .irq_count(irq_count), .busy(busy)
  );

  initial alu_clk = 1'b0;
  always #5 alu_clk = ~alu_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ALU behaviour: result from the opcode table, interrupt whenever operand a is all ones.
  function automatic data_t alu_fn(input opcode_t op, input data_t a, input data_t b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SHL:  return a << 1;
      OP_SHR:  return a >> 1;
      default: return b;
    endcase
  endfunction

  // Sticky interrupt: stays set until the issuer pulses the clear.
  always @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      alu_out <= '0;
      alu_irq <= 1'b0;
    end else begin
      if (alu_irq_clr) alu_irq <= 1'b0;
      if (alu_enable) begin
        alu_out <= alu_fn(alu_enable_a ? alu_op_a : alu_op_b, alu_in_a, alu_in_b);
        if (alu_in_a == 8'hFF) alu_irq <= 1'b1;
      end
    end
  end

  // Monitor: records accepted commands, scores responses and per-cycle protocol rules.
  initial begin
    logic  prev_valid, prev_ready;
    data_t prev_data;
    cmd_t  c;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge alu_clk);
      if (!alu_rst_n) begin
        exp_q.delete();
        exp_irq_cnt = 0;
        prev_valid  = 1'b0;
        prev_ready  = 1'b0;
      end else begin
        check("en_exclusive", {31'd0, alu_enable_a & alu_enable_b}, 32'd0);
        check("en_consistent", {31'd0, alu_enable}, {31'd0, alu_enable_a | alu_enable_b});
        check("irq_clr_pulse", {31'd0, alu_irq_clr},
              {31'd0, rsp_valid && !prev_valid && rsp_irq});
        if (prev_valid && !prev_ready) begin
          check("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
          check("rsp_hold_data", {24'd0, rsp_data}, {24'd0, prev_data});
        end
        if (cmd_valid && cmd_ready) begin
          exp_q.push_back('{mode: cmd_mode, op: cmd_op, a: cmd_a, b: cmd_b});
          n_acc++;
        end
        if (rsp_valid && rsp_ready) begin
          n_rsp++;
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(n_rsp), 32'(n_acc));
          end else begin
            c = exp_q.pop_front();
            check("rsp_data", {24'd0, rsp_data}, {24'd0, alu_fn(c.op, c.a, c.b)});
            check("rsp_irq", {31'd0, rsp_irq}, {31'd0, c.a == 8'hFF});
            if (c.a == 8'hFF && exp_irq_cnt < 255) exp_irq_cnt++;
            check("irq_count", {24'd0, irq_count}, 32'(exp_irq_cnt));
          end
        end
        prev_valid = rsp_valid;
        prev_ready = rsp_ready;
        prev_data  = rsp_data;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic m, input opcode_t op, input data_t a, input data_t b);
    cmd_mode  = m;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge alu_clk);
      if (cmd_ready) begin
        @(posedge alu_clk);
        #1;
        cmd_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic send_rand(input logic allow_irq);
    data_t a;
    a = data_t'($urandom_range(0, 254));
    if (allow_irq && ($urandom_range(0, 3) == 0)) a = 8'hFF;
    send(1'($urandom_range(0, 1)), opcode_t'(3'($urandom_range(0, 7))), a,
         data_t'($urandom_range(0, 255)));
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge alu_clk);
      if (!busy && !rsp_valid && exp_q.size() == 0) begin
        check("no_loss_dup", 32'(n_rsp), 32'(n_acc));
        @(posedge alu_clk);
        #1;
        return;
      end
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    @(posedge alu_clk);
    #1;
  endtask

  task automatic tick();
    @(posedge alu_clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pulses[$];
    logic seen_valid;

    alu_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 1'b0;
    cmd_op    = OP_AND;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu_enable", {29'd0, alu_enable, alu_enable_a, alu_enable_b}, 32'd0);
    check("rst_op_a", {29'd0, alu_op_a}, {29'd0, OP_AND});
    check("rst_irq_count", {24'd0, irq_count}, 32'd0);
    @(negedge alu_clk);
    alu_rst_n = 1'b1;
    tick();

    // Single command, port A
    send(1'b0, OP_AND, 8'h3C, 8'h0F);
    tick();
    check("s_issue_en", {29'd0, alu_enable, alu_enable_a, alu_enable_b}, 32'b110);
    check("s_issue_op_a", {29'd0, alu_op_a}, {29'd0, OP_AND});
    check("s_issue_in", {16'd0, alu_in_a, alu_in_b}, 32'h3C0F);
    tick();
    check("s_wait_en", {31'd0, alu_enable}, 32'd0);
    check("s_wait_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("s_resp_valid", {31'd0, rsp_valid}, 32'd1);
    check("s_resp_data", {24'd0, rsp_data}, 32'h0C);
    check("s_resp_irq", {31'd0, rsp_irq}, 32'd0);
    check("s_resp_clr", {31'd0, alu_irq_clr}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Interrupting command, port B
    send(1'b1, OP_OR, 8'hFF, 8'h00);
    tick();
    check("i_issue_en", {29'd0, alu_enable, alu_enable_a, alu_enable_b}, 32'b101);
    check("i_issue_op_b", {29'd0, alu_op_b}, {29'd0, OP_OR});
    check("i_unused_op_a", {29'd0, alu_op_a}, {29'd0, OP_AND});
    repeat (2) tick();
    check("i_resp_irq", {31'd0, rsp_irq}, 32'd1);
    check("i_resp_data", {24'd0, rsp_data}, 32'hFF);
    check("i_clr_first", {31'd0, alu_irq_clr}, 32'd1);
    check("i_irq_count", {24'd0, irq_count}, 32'd1);
    tick();
    check("i_clr_second", {31'd0, alu_irq_clr}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    wait_idle(50);

    // Backpressure: fill to 1 in flight + 4 queued
    for (int i = 0; i < 5; i++) send_rand(1'b1);
    check("bp_full_ready", {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge alu_clk);
    check("bp_handshake", {31'd0, rsp_valid}, 32'd1);
    check("bp_ready_at_pop", {31'd0, cmd_ready}, 32'd0);
    tick();
    check("bp_ready_after_pop", {31'd0, cmd_ready}, 32'd1);
    send_rand(1'b1);
    wait_idle(200);

    // Back-to-back issue with ready held high
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_rand(1'b1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge alu_clk);
      if (alu_enable) pulses.push_back(i);
    end
    check("b2b_pulses", 32'(pulses.size()), 32'd4);
    for (int i = 1; i < pulses.size(); i++)
      check("b2b_spacing", 32'(pulses[i] - pulses[i-1]), 32'd3);
    tick();
    wait_idle(200);

    // Reset during WAIT with two commands queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_rand(1'b0);
    rsp_ready = 1'b1;
    @(negedge alu_clk);
    check("mr_first_rsp", {31'd0, rsp_valid}, 32'd1);
    tick();
    rsp_ready = 1'b0;
    tick();
    check("mr_in_wait", {31'd0, alu_enable | rsp_valid}, 32'd0);
    alu_rst_n = 1'b0;
    #1;
    check("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mr_alu_ctl", {28'd0, alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr}, 32'd0);
    check("mr_alu_ops", {26'd0, alu_op_a, alu_op_b}, {26'd0, OP_AND, OP_AND});
    check("mr_alu_in", {16'd0, alu_in_a, alu_in_b}, 32'd0);
    check("mr_rsp_regs", {23'd0, rsp_data, rsp_irq}, 32'd0);
    check("mr_irq_count", {24'd0, irq_count}, 32'd0);
    repeat (2) @(negedge alu_clk);
    #2;
    alu_rst_n = 1'b1;
    n_acc = 0;
    n_rsp = 0;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge alu_clk);
      seen_valid |= rsp_valid | busy;
    end
    check("mr_quiet_after", {31'd0, seen_valid}, 32'd0);
    tick();

    // Randomized traffic with random response backpressure
    begin
      logic done;
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 40; i++) send_rand(1'b1);
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge alu_clk);
            #1;
            rsp_ready = 1'($urandom_range(0, 1));
          end
        end
      join
    end
    rsp_ready = 1'b1;
    wait_idle(500);

    // Interrupt count saturation
    for (int i = 0; i < 256; i++)
      send(1'($urandom_range(0, 1)), opcode_t'(3'($urandom_range(0, 7))), 8'hFF,
           data_t'($urandom_range(0, 255)));
    wait_idle(2000);
    check("sat_irq_count", {24'd0, irq_count}, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
